// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes MIPS shifts into a 2-entry FIFO feeding the shifter.
// Optional SHIFT_VARIABLE_EN adds sllv/srlv/srav decode.
module shift_issue_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_funct,
  output logic [31:0] out_a,
  output logic [4:0]  out_N,
  output logic        out_illegal
);

  typedef struct packed {
    logic [1:0]  funct;
    logic [31:0] a;
    logic [4:0]  n;
    logic        illegal;
  } ent_t;

  localparam ent_t ENT_RST = '{
    funct: 2'b11, a: 32'd0, n: 5'd0, illegal: 1'b0
  };
  localparam ent_t ENT_ILL = '{
    funct: 2'b11, a: 32'd0, n: 5'd0, illegal: 1'b1
  };

  logic [1:0] count_q, count_d;
  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  ent_t       dec;
  logic       op_ok;
  logic [5:0] fn;
  logic       push, pop;
  logic       unused_ok;

  assign unused_ok = ^{instr[25:11], rs_val};

  always_comb begin
    dec   = ENT_ILL;
    op_ok = (instr[31:26] == 6'd0);
    fn    = instr[5:0];
    unique case (1'b1)
      op_ok && fn == 6'h00:
        dec = '{funct: 2'b00, a: rt_val, n: instr[10:6], illegal: 1'b0};
      op_ok && fn == 6'h02:
        dec = '{funct: 2'b01, a: rt_val, n: instr[10:6], illegal: 1'b0};
      op_ok && fn == 6'h03:
        dec = '{funct: 2'b10, a: rt_val, n: instr[10:6], illegal: 1'b0};
`ifdef SHIFT_VARIABLE_EN
      op_ok && fn == 6'h04:
        dec = '{funct: 2'b00, a: rt_val, n: rs_val[4:0], illegal: 1'b0};
      op_ok && fn == 6'h06:
        dec = '{funct: 2'b01, a: rt_val, n: rs_val[4:0], illegal: 1'b0};
      op_ok && fn == 6'h07:
        dec = '{funct: 2'b10, a: rt_val, n: rs_val[4:0], illegal: 1'b0};
`endif
      default: ;
    endcase
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Full FIFO never pushes, so pop at count 2 just promotes the tail.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = dec;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= ENT_RST;
      tail_q  <= ENT_RST;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_funct   = out_valid ? head_q.funct : 2'b11;
  assign out_a       = out_valid ? head_q.a : 32'd0;
  assign out_N       = out_valid ? head_q.n : 5'd0;
  assign out_illegal = out_valid ? head_q.illegal : 1'b0;

endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 SHALL have no parameters; buffer depth is fixed at 2 entries.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  discard all buffered entries (branch/exception squash).
REQ-005 SHALL have port in_valid  input  1  upstream presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port instr  input  32  raw MIPS instruction word.
REQ-008 SHALL have port rs_val  input  32  register-file value of rs.
REQ-009 SHALL have port rt_val  input  32  register-file value of rt.
REQ-010 SHALL have port out_valid  output  1  head entry valid toward the shifter.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head this cycle.
REQ-012 SHALL have port out_funct  output  2  shifter op: 00 sll, 01 srl, 10 sra, 11 none.
REQ-013 SHALL have port out_a  output  32  operand to shift.
REQ-014 SHALL have port out_N  output  5  shift amount.
REQ-015 SHALL have port out_illegal  output  1  head entry is not a supported shift.

Function
REQ-016 SHALL accept an entry iff in_valid && in_ready at a rising edge, and retire the head iff out_valid && out_ready.
REQ-017 SHALL hold entries in a 2-entry FIFO (count 0/1/2); out_* SHALL be driven from registers (head), never combinationally from inputs.
REQ-018 SHALL drive in_ready = (count != 2); simultaneous accept and retire at count 2 is not permitted (in_ready low), at count 1 SHALL keep count 1.
REQ-019 SHALL present an accepted entry on out_* with out_valid high exactly 1 cycle after acceptance when the FIFO was empty; sustained throughput 1 entry/cycle.
REQ-020 SHALL keep out_* stable while out_valid && !out_ready.
REQ-021 SHALL preserve FIFO order; second entry SHALL move to head the cycle after head retires.
REQ-022 SHALL decode at acceptance: opcode instr[31:26] must be 000000; funct instr[5:0].
REQ-023 SHALL map funct 000000 -> 00, 000010 -> 01, 000011 -> 10 with out_N = instr[10:6] and out_a = rt_val.
REQ-024 SHALL map variable shifts 000100 -> 00, 000110 -> 01, 000111 -> 10 with out_N = rs_val[4:0] and out_a = rt_val (see REQ-031).
REQ-025 SHALL, for any other opcode/funct, store out_funct=11, out_a=0, out_N=0, out_illegal=1; supported shifts store out_illegal=0.
REQ-026 SHALL, on flush high at a rising edge, set count to 0 and out_valid to 0 next cycle; an entry accepted in the same cycle SHALL be discarded; in_ready SHALL be 1 the following cycle.
REQ-027 SHALL ignore out_ready when out_valid is 0 and in_valid when in_ready is 0.

Reset
REQ-028 SHALL, while reset_n is low, force count=0, out_valid=0, out_funct=11, out_a=0, out_N=0, out_illegal=0, in_ready=1, independent of clk.
REQ-029 SHALL resume normal operation on the first rising edge after reset_n deasserts; reset mid-transfer SHALL drop all entries without emitting them.

Configuration
REQ-030 SHALL use macro SHIFT_VARIABLE_EN to control variable-shift support.
REQ-031 SHALL, with SHIFT_VARIABLE_EN defined, decode sllv/srlv/srav per REQ-024; without it, those funct codes SHALL be treated as illegal per REQ-025.

Verification
REQ-032 Reset: reset_n low mid-stream with count 2 -> out_valid 0, in_ready 1, out_funct 11 immediately; no entry emitted after release.
REQ-033 Fixed shift: instr 0x00041100 (sll $2,$4,4), rt_val 0x0000000F, out_ready 1 -> next cycle out_valid 1, out_funct 00, out_a 0x0000000F, out_N 4, out_illegal 0.
REQ-034 Variable shift: instr 0x00A41007 (srav $2,$4,$5), rs_val 0xFFFFFFE3, rt_val 0x80000000 -> out_funct 10, out_N 3; without SHIFT_VARIABLE_EN -> out_funct 11, out_illegal 1.
REQ-035 Backpressure: out_ready 0, three back-to-back in_valid -> two accepted, in_ready 0 after second; out_ready 1 -> entries emitted in order, in_ready returns 1 next cycle.
REQ-036 Flush: count 2, flush 1 with in_valid 1 same cycle -> next cycle out_valid 0, count 0, new entry not emitted.
REQ-037 Illegal: instr 0x00851020 (add) -> out_funct 11, out_a 0, out_N 0, out_illegal 1, out_valid 1.
